// File: rtl/byte_serial_sub.sv
// Streaming multi-word subtractor A-B, LSB word first, with a borrow chained across beats.
// One-cycle latency through a single output register; in_ready drops only while a held beat is stalled.
module byte_serial_sub #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_diff,
  output logic         out_first,
  output logic         out_last,
  output logic         out_borrow,
  output logic         out_zero
);

  typedef enum logic {S_IDLE, S_MID} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_brw;
  logic         r_zero_acc;
  logic         r_out_valid;
  logic [W-1:0] r_out_diff;
  logic         r_out_first;
  logic         r_out_last;
  logic         r_out_borrow;
  logic         r_out_zero;

  logic         w_accept;
  logic         w_first;
  logic         w_brw_in;
  logic [W:0]   w_t;
  logic         w_diff_zero;

  assign in_ready = !r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_first     = 1'b0;
    w_brw_in    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_first = 1'b1;
        if (w_accept && !in_last) w_state_nxt = S_MID;
      end
      S_MID: begin
        w_brw_in = r_brw;
        if (w_accept && in_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Full W+1-bit subtract so the top bit is the true borrow out of this word.
  assign w_t         = {1'b0, in_a} - {1'b0, in_b} - {{W{1'b0}}, w_brw_in};
  assign w_diff_zero = (w_t[W-1:0] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_brw      <= 1'b0;
      r_zero_acc <= 1'b1;
    end else if (w_accept) begin
      r_state    <= w_state_nxt;
      r_brw      <= in_last ? 1'b0 : w_t[W];
      r_zero_acc <= in_last ? 1'b1 : (r_zero_acc & w_diff_zero);
    end
  end

  // A new accept overwrites the output beat in the same edge it transfers out, so no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_diff   <= '0;
      r_out_first  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_borrow <= 1'b0;
      r_out_zero   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_diff   <= w_t[W-1:0];
      r_out_first  <= w_first;
      r_out_last   <= in_last;
      r_out_borrow <= w_t[W];
      r_out_zero   <= in_last & r_zero_acc & w_diff_zero;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_diff   = r_out_diff;
  assign out_first  = r_out_first;
  assign out_last   = r_out_last;
  assign out_borrow = r_out_borrow;
  assign out_zero   = r_out_zero;

endmodule
